// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen APB4 adapter: response status codes,
// adapter FSM states and the timeout counter sizing rule.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    OKAY         = 2'b00,
    EXOKAY       = 2'b01,
    SLAVE_ERROR  = 2'b10,
    DECODE_ERROR = 2'b11
  } rggen_status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } rggen_adapter_state_e;

  // Counter must represent 0..cycles; never narrower than one bit.
  function automatic int unsigned rggen_counter_width(int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rggen_apb4_adapter_ext_if.sv
// APB4 bus bundle between the system interconnect (master) and the adapter (slave).
interface rggen_apb4_adapter_ext_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
);

  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;

  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [STRB_WIDTH-1:0]    pstrb;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/rggen_adapter_timeout_counter.sv
// Saturating ACCESS-cycle counter; o_expired flags the last permitted wait cycle.
module rggen_adapter_timeout_counter
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned COUNT_WIDTH = rggen_counter_width(TIMEOUT_CYCLES);
  localparam int unsigned LAST_VALUE  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(LAST_VALUE);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   expired_q;
  logic                   expired_d;

  // expired_q tracks the registered count, so it is true exactly while count_q sits on the last cycle
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
    expired_d = (TIMEOUT_CYCLES != 0) && (count_d == COUNT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;

endmodule

// File: rtl/rggen_apb4_adapter_ext.sv
// APB4 slave front end for rggen register blocks: window/privilege decode,
// one register-side request per transfer, and a bounded wait for i_ready.
module rggen_apb4_adapter_ext
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned            ADDRESS_WIDTH   = 8,
  parameter int unsigned            BUS_WIDTH       = 32,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
  parameter int unsigned            BYTE_SIZE       = 256,
  parameter bit                     ERROR_STATUS    = 1'b1,
  parameter bit                     PRIVILEGED_ONLY = 1'b0,
  parameter int unsigned            TIMEOUT_CYCLES  = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  rggen_apb4_adapter_ext_if.slave      apb,
  output logic                         o_valid,
  output logic [ADDRESS_WIDTH-1:0]     o_address,
  output logic                         o_write,
  output logic [BUS_WIDTH-1:0]         o_write_data,
  output logic [BUS_WIDTH/8-1:0]       o_strobe,
  input  logic                         i_ready,
  input  logic [1:0]                   i_status,
  input  logic [BUS_WIDTH-1:0]         i_read_data,
  output logic                         o_timeout
);

  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned CMP_WIDTH  = ADDRESS_WIDTH + 1;
  localparam logic [CMP_WIDTH-1:0] WINDOW_LO = CMP_WIDTH'(BASE_ADDRESS);
  localparam logic [CMP_WIDTH-1:0] WINDOW_HI = WINDOW_LO + CMP_WIDTH'(BYTE_SIZE);

  rggen_adapter_state_e     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0]    strobe_q, strobe_d;
  logic                     valid_q, valid_d;
  logic                     decode_err_q, decode_err_d;
  logic                     discard_q, discard_d;
  logic                     pready_q, pready_d;
  logic [BUS_WIDTH-1:0]     prdata_q, prdata_d;
  logic                     pslverr_q, pslverr_d;

  logic [CMP_WIDTH-1:0] paddr_ext;
  logic                 window_hit;
  logic                 privilege_fail;
  logic                 status_err;
  logic                 respond_ok;
  logic                 expired;
  logic                 timeout_fire;
  logic                 counter_clear;
  logic                 counter_count;
  logic                 unused_prot;

  assign paddr_ext      = CMP_WIDTH'(apb.paddr);
  assign window_hit     = (paddr_ext >= WINDOW_LO) && (paddr_ext < WINDOW_HI);
  assign privilege_fail = PRIVILEGED_ONLY && !apb.pprot[0];
  assign unused_prot    = ^apb.pprot;
  assign status_err     = (rggen_status_e'(i_status) == SLAVE_ERROR) ||
                          (rggen_status_e'(i_status) == DECODE_ERROR);
  // A response is only presented to a master that is still in its access phase
  assign respond_ok     = !discard_q && apb.psel && apb.penable;
  assign timeout_fire   = (state_q == ACCESS) && !decode_err_q && !i_ready && expired;

  rggen_adapter_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (counter_clear),
    .i_count   (counter_count),
    .o_expired (expired)
  );

  // Next-state and next-register logic; decode errors spend their access-phase
  // cycle in ACCESS with the request masked so every response has the same latency.
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    write_d       = write_q;
    write_data_d  = write_data_q;
    strobe_d      = strobe_q;
    decode_err_d  = decode_err_q;
    discard_d     = discard_q;
    valid_d       = 1'b0;
    pready_d      = 1'b0;
    prdata_d      = '0;
    pslverr_d     = 1'b0;
    counter_clear = 1'b1;
    counter_count = 1'b0;

    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          address_d    = apb.paddr;
          write_d      = apb.pwrite;
          write_data_d = apb.pwdata;
          strobe_d     = apb.pwrite ? apb.pstrb : '1;
          decode_err_d = !window_hit || privilege_fail;
          discard_d    = 1'b0;
          valid_d      = window_hit && !privilege_fail;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        counter_clear = 1'b0;
        counter_count = !i_ready && !decode_err_q;
        discard_d     = discard_q || !apb.psel;
        if (decode_err_q) begin
          pready_d  = respond_ok;
          pslverr_d = ERROR_STATUS;
          state_d   = RESPOND;
        end else if (i_ready) begin
          pready_d  = respond_ok;
          prdata_d  = write_q ? '0 : i_read_data;
          pslverr_d = status_err && ERROR_STATUS;
          state_d   = RESPOND;
        end else if (timeout_fire) begin
          pready_d  = respond_ok;
          pslverr_d = ERROR_STATUS;
          state_d   = RESPOND;
        end else begin
          valid_d = 1'b1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      strobe_q     <= '0;
      decode_err_q <= 1'b0;
      discard_q    <= 1'b0;
      valid_q      <= 1'b0;
      pready_q     <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      decode_err_q <= decode_err_d;
      discard_q    <= discard_d;
      valid_q      <= valid_d;
      pready_q     <= pready_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
    end
  end

  assign apb.pready   = pready_q;
  assign apb.prdata   = prdata_q;
  assign apb.pslverr  = pslverr_q;
  assign o_valid      = valid_q;
  assign o_address    = address_q;
  assign o_write      = write_q;
  assign o_write_data = write_data_q;
  assign o_strobe     = strobe_q;
  assign o_timeout    = timeout_fire;

endmodule

// File: tb/tb_rggen_apb4_adapter_ext.sv
// Directed bench for rggen_apb4_adapter_ext: three configurations share one APB
// stimulus and one register-side responder; each step checks the relevant instance.
module tb_rggen_apb4_adapter_ext;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        ready;
  logic [1:0]  status;
  logic [31:0] rdata;

  int checks;
  int failures;

  logic        valid_a, write_a, timeout_a;
  logic [7:0]  address_a;
  logic [31:0] wdata_a;
  logic [3:0]  strobe_a;
  logic        valid_b, write_b, timeout_b;
  logic [7:0]  address_b;
  logic [31:0] wdata_b;
  logic [3:0]  strobe_b;
  logic        valid_c, write_c, timeout_c;
  logic [7:0]  address_c;
  logic [31:0] wdata_c;
  logic [3:0]  strobe_c;

  rggen_apb4_adapter_ext_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) if_a ();
  rggen_apb4_adapter_ext_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) if_b ();
  rggen_apb4_adapter_ext_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) if_c ();

  assign if_a.psel = psel;  assign if_a.penable = penable; assign if_a.paddr = paddr;
  assign if_a.pprot = pprot; assign if_a.pwrite = pwrite;  assign if_a.pwdata = pwdata;
  assign if_a.pstrb = pstrb;
  assign if_b.psel = psel;  assign if_b.penable = penable; assign if_b.paddr = paddr;
  assign if_b.pprot = pprot; assign if_b.pwrite = pwrite;  assign if_b.pwdata = pwdata;
  assign if_b.pstrb = pstrb;
  assign if_c.psel = psel;  assign if_c.penable = penable; assign if_c.paddr = paddr;
  assign if_c.pprot = pprot; assign if_c.pwrite = pwrite;  assign if_c.pwdata = pwdata;
  assign if_c.pstrb = pstrb;

  // Default configuration: full 256-byte window, no timeout
  rggen_apb4_adapter_ext #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .BASE_ADDRESS(8'h00), .BYTE_SIZE(256),
    .ERROR_STATUS(1'b1), .PRIVILEGED_ONLY(1'b0), .TIMEOUT_CYCLES(0)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .apb(if_a),
    .o_valid(valid_a), .o_address(address_a), .o_write(write_a),
    .o_write_data(wdata_a), .o_strobe(strobe_a),
    .i_ready(ready), .i_status(status), .i_read_data(rdata), .o_timeout(timeout_a)
  );

  // Window 0x40..0x5F, privileged only, 4-cycle timeout
  rggen_apb4_adapter_ext #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .BASE_ADDRESS(8'h40), .BYTE_SIZE(32),
    .ERROR_STATUS(1'b1), .PRIVILEGED_ONLY(1'b1), .TIMEOUT_CYCLES(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .apb(if_b),
    .o_valid(valid_b), .o_address(address_b), .o_write(write_b),
    .o_write_data(wdata_b), .o_strobe(strobe_b),
    .i_ready(ready), .i_status(status), .i_read_data(rdata), .o_timeout(timeout_b)
  );

  // Errors suppressed from pslverr
  rggen_apb4_adapter_ext #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .BASE_ADDRESS(8'h00), .BYTE_SIZE(256),
    .ERROR_STATUS(1'b0), .PRIVILEGED_ONLY(1'b0), .TIMEOUT_CYCLES(0)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .apb(if_c),
    .o_valid(valid_c), .o_address(address_c), .o_write(write_c),
    .o_write_data(wdata_c), .o_strobe(strobe_c),
    .i_ready(ready), .i_status(status), .i_read_data(rdata), .o_timeout(timeout_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pprot = 3'b000;
    pwdata = 32'h0; pstrb = 4'h0; ready = 1'b0; status = 2'b00; rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    adv();
    rst = 1'b0;
  endtask

  task automatic respond(input logic r, input logic [1:0] s, input logic [31:0] d);
    ready = r; status = s; rdata = d;
  endtask

  // Drives the setup phase and returns at the start of the first access cycle
  task automatic setup(input logic [7:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [2:0] pr);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = sb;
    pprot = pr; ready = 1'b0;
    adv();
    penable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_bus();
    adv();
    adv();
    @(negedge clk);
    check("rst_flags_a", {if_a.pready, if_a.pslverr, valid_a, write_a, timeout_a}, 5'b0);
    check("rst_prdata_a", if_a.prdata, 32'h0);
    check("rst_req_a", {address_a, strobe_a, wdata_a}, 44'h0);
    check("rst_flags_b", {if_b.pready, if_b.pslverr, valid_b, timeout_b}, 4'b0);

    // Read 0x10, ready in the first access cycle
    do_reset();
    setup(8'h10, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_valid", valid_a, 1'b1);
    check("rd_addr", address_a, 8'h10);
    check("rd_strobe", {write_a, strobe_a}, 5'b0_1111);
    check("rd_early_pready", if_a.pready, 1'b0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("rd_pready", if_a.pready, 1'b1);
    check("rd_prdata", if_a.prdata, 32'hDEADBEEF);
    check("rd_pslverr", if_a.pslverr, 1'b0);
    check("rd_valid_drop", valid_a, 1'b0);
    adv();
    idle_bus();
    @(negedge clk);
    check("rd_pready_once", if_a.pready, 1'b0);

    // Write 0x04, ready on the fourth access cycle
    do_reset();
    setup(8'h04, 1'b1, 32'h12345678, 4'b0011, 3'b001);
    respond(1'b0, 2'b00, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr_valid", valid_a, 1'b1);
      check("wr_payload", {write_a, strobe_a, wdata_a}, {1'b1, 4'b0011, 32'h12345678});
      check("wr_addr", address_a, 8'h04);
      check("wr_no_pready", if_a.pready, 1'b0);
      adv();
    end
    respond(1'b1, 2'b00, 32'hAAAA5555);
    @(negedge clk);
    check("wr_payload_last", {valid_a, strobe_a, wdata_a}, {1'b1, 4'b0011, 32'h12345678});
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("wr_pready", if_a.pready, 1'b1);
    check("wr_prdata_zero", if_a.prdata, 32'h0);
    check("wr_pslverr", if_a.pslverr, 1'b0);
    adv();
    idle_bus();

    // Window miss just above the window
    do_reset();
    setup(8'h60, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'h12345678);
    @(negedge clk);
    check("win_hi_valid", valid_b, 1'b0);
    check("win_hi_early", if_b.pready, 1'b0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("win_hi_pready", if_b.pready, 1'b1);
    check("win_hi_pslverr", if_b.pslverr, 1'b1);
    check("win_hi_prdata", if_b.prdata, 32'h0);
    check("win_hi_valid2", valid_b, 1'b0);
    adv();
    idle_bus();

    // Last byte inside the window
    do_reset();
    setup(8'h5F, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'h0BADF00D);
    @(negedge clk);
    check("win_last_valid", valid_b, 1'b1);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("win_last_resp", {if_b.pready, if_b.pslverr}, 2'b10);
    check("win_last_prdata", if_b.prdata, 32'h0BADF00D);
    adv();
    idle_bus();

    // Window miss just below the window
    do_reset();
    setup(8'h3F, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'h0);
    @(negedge clk);
    check("win_lo_valid", valid_b, 1'b0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("win_lo_resp", {if_b.pready, if_b.pslverr}, 2'b11);
    adv();
    idle_bus();

    // Timeout after four access cycles without ready
    do_reset();
    setup(8'h44, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b0, 2'b00, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to_wait", {valid_b, timeout_b, if_b.pready}, 3'b100);
      adv();
    end
    @(negedge clk);
    check("to_pulse", {timeout_b, if_b.pready}, 2'b10);
    adv();
    @(negedge clk);
    check("to_resp", {if_b.pready, if_b.pslverr, timeout_b, valid_b}, 4'b1100);
    check("to_prdata", if_b.prdata, 32'h0);
    adv();
    idle_bus();

    // Ready in the same cycle as the timeout wins
    do_reset();
    setup(8'h44, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b0, 2'b00, 32'h0);
    adv();
    adv();
    adv();
    respond(1'b1, 2'b00, 32'h11223344);
    @(negedge clk);
    check("to_race_pulse", timeout_b, 1'b0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("to_race_resp", {if_b.pready, if_b.pslverr}, 2'b10);
    check("to_race_prdata", if_b.prdata, 32'h11223344);
    adv();
    idle_bus();

    // Decode-error status from the register side, with and without ERROR_STATUS
    do_reset();
    setup(8'h20, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b11, 32'h55AA55AA);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("st11_a", {if_a.pready, if_a.pslverr}, 2'b11);
    check("st11_c", {if_c.pready, if_c.pslverr}, 2'b10);
    check("st11_prdata", if_a.prdata, 32'h55AA55AA);
    adv();
    idle_bus();

    do_reset();
    setup(8'h24, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b10, 32'h0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("st10_a", {if_a.pready, if_a.pslverr}, 2'b11);
    adv();
    idle_bus();

    do_reset();
    setup(8'h28, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b01, 32'h0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("st01_a", {if_a.pready, if_a.pslverr}, 2'b10);
    adv();
    idle_bus();

    // Unprivileged access inside the window
    do_reset();
    setup(8'h48, 1'b0, 32'h0, 4'h0, 3'b000);
    respond(1'b1, 2'b00, 32'h0);
    @(negedge clk);
    check("priv_valid", valid_b, 1'b0);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("priv_resp_b", {if_b.pready, if_b.pslverr}, 2'b11);
    check("priv_resp_a", {if_a.pready, if_a.pslverr}, 2'b10);
    adv();
    idle_bus();

    // Reset during ACCESS, then a normal transfer
    do_reset();
    setup(8'h08, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("rstmid_valid", valid_a, 1'b1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    idle_bus();
    @(negedge clk);
    check("rstmid_flags", {if_a.pready, valid_a, if_a.pslverr, timeout_a}, 4'b0);
    check("rstmid_addr", address_a, 8'h00);
    adv();
    setup(8'h0C, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'hCAFEF00D);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("rstmid_next", {if_a.pready, if_a.pslverr}, 2'b10);
    check("rstmid_next_data", if_a.prdata, 32'hCAFEF00D);
    adv();
    idle_bus();

    // Back-to-back reads with no idle cycle between them
    do_reset();
    setup(8'h30, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'h00000001);
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("b2b_first", if_a.prdata, 32'h00000001);
    adv();
    setup(8'h34, 1'b0, 32'h0, 4'h0, 3'b001);
    respond(1'b1, 2'b00, 32'h00000002);
    @(negedge clk);
    check("b2b_second_req", {valid_a, address_a}, {1'b1, 8'h34});
    adv();
    respond(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    check("b2b_second_resp", {if_a.pready, if_a.prdata}, {1'b1, 32'h00000002});
    adv();
    idle_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
